// File: rtl/sdram_port_arb.sv
// rtl/sdram_port_arb.sv - two-port burst-locked arbiter in front of the SDRAM core request port
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module sdram_port_arb #(
  parameter int CNT_W = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_wr_i,
  input  logic        m0_rd_i,
  input  logic [7:0]  m0_len_i,
  input  logic [31:0] m0_write_data_i,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic        m0_error_o,
  output logic [31:0] m0_read_data_o,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_wr_i,
  input  logic        m1_rd_i,
  input  logic [7:0]  m1_len_i,
  input  logic [31:0] m1_write_data_i,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic        m1_error_o,
  output logic [31:0] m1_read_data_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_wr_o,
  output logic        ram_rd_o,
  output logic [7:0]  ram_len_o,
  output logic [31:0] ram_write_data_o,
  input  logic        ram_accept_i,
  input  logic        ram_ack_i,
  input  logic        ram_error_i,
  input  logic [31:0] ram_read_data_i
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   accepts_left_q, accepts_left_d;
  logic [CNT_W-1:0]   acks_left_q, acks_left_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic               last_grant_q, last_grant_d;
`endif

  logic               req0, req1, any_req, cand, sel;
  logic               sel_rd;
  logic [3:0]         sel_wr;
  logic [7:0]         sel_len;
  logic               idle_grant, busy_accept, routed, route_ack;
  logic [CNT_W-1:0]   burst_beats, acks_after_grant;

  assign req0    = m0_rd_i | (m0_wr_i != 4'd0);
  assign req1    = m1_rd_i | (m1_wr_i != 4'd0);
  assign any_req = req0 | req1;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign cand = ~req0 & req1;
`else
  assign cand = (req0 & req1) ? ~last_grant_q : (~req0 & req1);
`endif

  // Once busy, only the owner may drive the core until its burst drains.
  assign sel     = (state_q == ST_BUSY) ? owner_q : cand;
  assign sel_rd  = sel ? m1_rd_i  : m0_rd_i;
  assign sel_wr  = sel ? m1_wr_i  : m0_wr_i;
  assign sel_len = sel ? m1_len_i : m0_len_i;

  assign idle_grant  = (state_q == ST_IDLE) & any_req & ram_accept_i;
  assign busy_accept = (state_q == ST_BUSY) & ram_accept_i & (accepts_left_q != '0);
  assign routed      = (state_q == ST_BUSY) | (idle_grant & ram_ack_i);
  assign route_ack   = routed & ram_ack_i;

  assign burst_beats      = CNT_W'(sel_len) + CNT_W'(1);
  assign acks_after_grant = ram_ack_i ? burst_beats - CNT_W'(1) : burst_beats;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      owner_q        <= 1'b0;
      accepts_left_q <= '0;
      acks_left_q    <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_grant_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      accepts_left_q <= accepts_left_d;
      acks_left_q    <= acks_left_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    accepts_left_d = accepts_left_q;
    acks_left_d    = acks_left_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    last_grant_d   = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (idle_grant) begin
          owner_d        = cand;
          accepts_left_d = (sel_wr != 4'd0) ? CNT_W'(sel_len) : '0;
          acks_left_d    = acks_after_grant;
          // Zero-latency single-beat burst completes within the grant cycle.
          if (acks_after_grant == '0) begin
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_grant_d = cand;
`endif
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      default: begin
        if (busy_accept) begin
          accepts_left_d = accepts_left_q - CNT_W'(1);
        end
        if (ram_ack_i && (acks_left_q != '0)) begin
          acks_left_d = acks_left_q - CNT_W'(1);
          if (acks_left_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_grant_d = owner_q;
`endif
          end
        end
      end
    endcase
  end

  always_comb begin
    ram_addr_o       = sel ? m1_addr_i : m0_addr_i;
    ram_len_o        = sel_len;
    ram_write_data_o = sel ? m1_write_data_i : m0_write_data_i;
    ram_rd_o         = 1'b0;
    ram_wr_o         = 4'd0;
    m0_accept_o      = 1'b0;
    m1_accept_o      = 1'b0;
    m0_ack_o         = 1'b0;
    m1_ack_o         = 1'b0;
    m0_error_o       = 1'b0;
    m1_error_o       = 1'b0;
    m0_read_data_o   = 32'd0;
    m1_read_data_o   = 32'd0;
    if (!rst_i) begin
      if (state_q == ST_IDLE) begin
        ram_rd_o = any_req & sel_rd;
        ram_wr_o = any_req ? sel_wr : 4'd0;
      end else begin
        ram_wr_o = (accepts_left_q != '0) ? sel_wr : 4'd0;
      end
      m0_accept_o = (idle_grant | busy_accept) & ~sel;
      m1_accept_o = (idle_grant | busy_accept) & sel;
      m0_ack_o    = route_ack & ~sel;
      m1_ack_o    = route_ack & sel;
      m0_error_o  = route_ack & ram_error_i & ~sel;
      m1_error_o  = route_ack & ram_error_i & sel;
      if (routed && !sel) m0_read_data_o = ram_read_data_i;
      if (routed && sel)  m1_read_data_o = ram_read_data_i;
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb/tb_sdram_port_arb.sv - scoreboard bench for sdram_port_arb
module tb_sdram_port_arb;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  localparam int FIXED = 1;
`else
  localparam int FIXED = 0;
`endif

  logic        clk, rst;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wr, m1_wr;
  logic        m0_rd, m1_rd;
  logic [7:0]  m0_len, m1_len;
  logic        m0_accept, m0_ack, m0_error, m1_accept, m1_ack, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_wr;
  logic        ram_rd, ram_accept, ram_ack, ram_error;
  logic [7:0]  ram_len;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  sdram_port_arb #(.CNT_W(9)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_addr_i(m0_addr), .m0_wr_i(m0_wr), .m0_rd_i(m0_rd), .m0_len_i(m0_len),
    .m0_write_data_i(m0_wdata), .m0_accept_o(m0_accept), .m0_ack_o(m0_ack),
    .m0_error_o(m0_error), .m0_read_data_o(m0_rdata),
    .m1_addr_i(m1_addr), .m1_wr_i(m1_wr), .m1_rd_i(m1_rd), .m1_len_i(m1_len),
    .m1_write_data_i(m1_wdata), .m1_accept_o(m1_accept), .m1_ack_o(m1_ack),
    .m1_error_o(m1_error), .m1_read_data_o(m1_rdata),
    .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_len_o(ram_len),
    .ram_write_data_o(ram_wdata), .ram_accept_i(ram_accept), .ram_ack_i(ram_ack),
    .ram_error_i(ram_error), .ram_read_data_i(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic core(input bit acc, input bit ack, input bit err, input logic [31:0] d, input int port);
    ram_accept = acc;
    ram_ack    = ack;
    ram_error  = err;
    ram_rdata  = d;
    if (ack && port >= 0) sb.push_back('{port: port, data: d, err: err});
  endtask

  task automatic idle_all();
    m0_rd = 0; m1_rd = 0; m0_wr = 4'd0; m1_wr = 4'd0;
    m0_len = 8'd0; m1_len = 8'd0;
    core(0, 0, 0, 32'd0, -1);
  endtask

  // Routed acks are popped against the expectations pushed when the core ack was driven.
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", {31'd0, m1_ack}, mon_e.port);
        check("ack_both", {31'd0, m0_ack & m1_ack}, 32'd0);
        check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, mon_e.data);
        check("ack_err", {31'd0, m1_ack ? m1_error : m0_error}, {31'd0, mon_e.err});
        check("other_rdata", m1_ack ? m0_rdata : m1_rdata, 32'd0);
      end
    end
    check("sb_drain", sb.size(), 32'd0);
  end

  initial begin
    rst = 1;
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
    m0_wdata = 32'hA0A0_0000; m1_wdata = 32'hB1B1_0000;
    idle_all();
    m0_rd = 1; m1_rd = 1; ram_accept = 1; ram_ack = 1; ram_rdata = 32'hDEAD_BEEF;
    sample();
    check("rst_ram_rd", ram_rd, 0);
    check("rst_accepts", {m0_accept, m1_accept}, 0);
    check("rst_acks", {m0_ack, m1_ack, m0_error, m1_error}, 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    next_cycle();
    rst = 0;
    idle_all();
    sample();
    check("idle_ram_rd", ram_rd, 0);
    check("idle_ram_wr", ram_wr, 0);
    check("idle_ram_addr", ram_addr, m0_addr);
    next_cycle();

    // single read len=3 on port 0, m1 waits throughout
    m0_rd = 1; m0_len = 8'd3; m0_addr = 32'h0000_0100;
    core(1, 0, 0, 32'd0, -1);
    sample();
    check("rd_m0_accept", m0_accept, 1);
    check("rd_m1_accept", m1_accept, 0);
    check("rd_ram_rd", ram_rd, 1);
    check("rd_ram_addr", ram_addr, 32'h0000_0100);
    check("rd_ram_len", ram_len, 3);
    next_cycle();
    m0_rd = 0;
    m1_rd = 1; m1_len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      core(1, 1, 0, 32'h1111_0000 + i, 0);
      sample();
      check("rd_busy_ram_rd", ram_rd, 0);
      check("rd_busy_m1_accept", m1_accept, 0);
      check("rd_busy_m0_accept", m0_accept, 0);
      next_cycle();
    end

    // m1 now alone in IDLE; zero-latency core: accept and final ack together
    core(1, 1, 0, 32'h2222_0001, 1);
    sample();
    check("zl_m1_accept", m1_accept, 1);
    check("zl_m0_accept", m0_accept, 0);
    next_cycle();
    idle_all();
    sample();
    check("zl_back_idle_rd", ram_rd, 0);
    next_cycle();

    // tie: last grant was m1, so m0 wins round-robin too
    m0_rd = 1; m1_rd = 1;
    core(1, 0, 0, 32'd0, -1);
    sample();
    check("tie1_m0_accept", m0_accept, 1);
    check("tie1_m1_accept", m1_accept, 0);
    next_cycle();
    m0_rd = 0;
    core(0, 1, 0, 32'h3333_0000, 0);
    next_cycle();
    m0_rd = 1;
    core(1, 0, 0, 32'd0, -1);
    sample();
    check("tie2_m1_accept", m1_accept, (FIXED == 0) ? 32'd1 : 32'd0);
    check("tie2_m0_accept", m0_accept, (FIXED == 0) ? 32'd0 : 32'd1);
    next_cycle();
    m0_rd = 0; m1_rd = 0;
    core(0, 1, 0, 32'h3333_0001, (FIXED == 0) ? 1 : 0);
    next_cycle();
    idle_all();
    next_cycle();

    // write burst on m1, m0 read arrives mid-burst and must wait
    m1_wr = 4'hF; m1_len = 8'd1; m1_wdata = 32'hB1B1_0000;
    core(1, 0, 0, 32'd0, -1);
    sample();
    check("wr_b0_accept", m1_accept, 1);
    check("wr_b0_ram_wr", ram_wr, 4'hF);
    check("wr_b0_data", ram_wdata, 32'hB1B1_0000);
    next_cycle();
    m1_wdata = 32'hB1B1_0001; m0_rd = 1; m0_len = 8'd0;
    sample();
    check("wr_b1_accept", m1_accept, 1);
    check("wr_b1_m0_accept", m0_accept, 0);
    check("wr_b1_data", ram_wdata, 32'hB1B1_0001);
    check("wr_b1_ram_rd", ram_rd, 0);
    next_cycle();
    m1_wr = 4'h0;
    core(1, 1, 0, 32'h4444_0000, 1);
    sample();
    check("wr_ack1_m0_accept", m0_accept, 0);
    check("wr_ack1_m1_accept", m1_accept, 0);
    check("wr_ack1_ram_wr", ram_wr, 0);
    next_cycle();
    core(1, 1, 0, 32'h4444_0001, 1);
    sample();
    check("wr_ack2_m0_accept", m0_accept, 0);
    next_cycle();
    core(1, 0, 0, 32'd0, -1);
    sample();
    check("wr_after_m0_accept", m0_accept, 1);
    next_cycle();
    m0_rd = 0;
    core(0, 1, 0, 32'h5555_0000, 0);
    next_cycle();

    // m1 read len=2 with an error on the second beat
    idle_all();
    m1_rd = 1; m1_len = 8'd2;
    core(1, 0, 0, 32'd0, -1);
    sample();
    check("err_m1_accept", m1_accept, 1);
    next_cycle();
    m1_rd = 0;
    for (int i = 0; i < 3; i++) begin
      core(0, 1, (i == 1), 32'h6666_0000 + i, 1);
      next_cycle();
    end
    core(0, 1, 0, 32'h7777_0000, -1);
    sample();
    check("spurious_acks", {m0_ack, m1_ack}, 0);
    check("post_err_idle_rd", ram_rd, 0);
    next_cycle();

    // reset mid-burst after one of four acks
    idle_all();
    m0_rd = 1; m0_len = 8'd3;
    core(1, 0, 0, 32'd0, -1);
    next_cycle();
    m0_rd = 0;
    core(0, 1, 0, 32'h8888_0000, 0);
    next_cycle();
    rst = 1;
    m0_rd = 1; m1_rd = 1; m0_len = 8'd0; m1_len = 8'd0;
    core(1, 1, 1, 32'h9999_0000, -1);
    sample();
    check("mrst_ram_rd", ram_rd, 0);
    check("mrst_ram_wr", ram_wr, 0);
    check("mrst_outs", {m0_accept, m1_accept, m0_ack, m1_ack, m0_error, m1_error}, 0);
    check("mrst_rdata", m0_rdata | m1_rdata, 0);
    next_cycle();
    rst = 0;
    core(1, 0, 0, 32'd0, -1);
    sample();
    check("mrst_tie_m0", m0_accept, 1);
    check("mrst_tie_m1", m1_accept, 0);
    next_cycle();
    m0_rd = 0; m1_rd = 0;
    core(0, 1, 0, 32'hAAAA_0000, 0);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
    check("sb_final_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Two-port arbiter sharing the single request/ack RAM port of the SDRAM controller core between two requesters (e.g. AXI bridge and a DMA/refresh-side agent). Sits between the requesters and the core's `inport_*` interface. Grants one port per burst and locks the grant until every beat of that burst has been acknowledged. Arbitration is round-robin by default, or fixed priority when configured.

## Interface
- `CNT_W`, default 9: width of the beat counters; must hold `len+1` for `len` up to 255.
- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `m0_addr_i` / `m1_addr_i`  in  32  request address.
- `m0_wr_i` / `m1_wr_i`  in  4  write byte strobes; nonzero means write beat.
- `m0_rd_i` / `m1_rd_i`  in  1  read burst request.
- `m0_len_i` / `m1_len_i`  in  8  burst length minus one.
- `m0_write_data_i` / `m1_write_data_i`  in  32  write data.
- `m0_accept_o` / `m1_accept_o`  out  1  request/beat accepted.
- `m0_ack_o` / `m1_ack_o`  out  1  beat completed.
- `m0_error_o` / `m1_error_o`  out  1  beat error, valid with ack.
- `m0_read_data_o` / `m1_read_data_o`  out  32  read data, valid with ack.
- `ram_addr_o`, `ram_wr_o`(4), `ram_rd_o`, `ram_len_o`(8), `ram_write_data_o`(32)  out  selected request to core.
- `ram_accept_i`, `ram_ack_i`, `ram_error_i`  in  1  core handshake.
- `ram_read_data_i`  in  32  core read data.

## Operation
- Request semantics: read = one accepted command, then `len+1` acks. Write = `len+1` accepted beats (each with nonzero `wr`), then `len+1` acks total.
- States: IDLE, BUSY. Registers: `owner` (1b), `last_grant` (1b), `accepts_left`, `acks_left` (CNT_W each).
- IDLE: candidate chosen combinationally each cycle from ports with `rd` or `wr!=0`. Round-robin: if both request, pick `!last_grant`; else the single requester. Candidate's request driven to `ram_*` same cycle. No request: `ram_rd_o=0`, `ram_wr_o=0`, other `ram_*` = port 0 values.
- IDLE, candidate and `ram_accept_i=1`: `owner<=candidate`, `acks_left<=len+1`, `accepts_left<=` 0 for read, `len` for write; go BUSY. Candidate may change/drop before accept without penalty.
- BUSY: only `owner` muxed to `ram_*`; for reads `ram_rd_o` forced 0 (command already issued); for writes `ram_wr_o` passes owner's beats while `accepts_left!=0`, else forced 0. Each `ram_accept_i` decrements `accepts_left`; each `ram_ack_i` decrements `acks_left`.
- Ack with `acks_left==1`: go IDLE, `last_grant<=owner`.
- `ram_ack_i`, `ram_error_i`, `ram_read_data_i` routed only to `owner` (in BUSY) or to IDLE candidate if ack coincides with accept (read latency 0 core case); other port sees ack=0, error=0, read_data=0.
- `accept` to non-owner always 0. Non-owner requests wait; no starvation under round-robin.
- Spurious `ram_ack_i` in IDLE with no accept: ignored.

## Timing
- Grant latency: zero cycles — accept can return in the same cycle a request first appears in IDLE.
- Back-to-back: final ack cycle returns to IDLE; next grant can be accepted the following cycle (one-cycle bubble minimum).
- Simultaneous accept and ack in same cycle: both counters decrement in that cycle.
- Reset: while `rst_i=1`, `ram_rd_o=0`, `ram_wr_o=0`, all `m*_accept_o`, `m*_ack_o`, `m*_error_o`=0, read data 0. Next cycle: IDLE, `owner=0`, `last_grant=1` (port 0 wins first tie), counters 0. Reset mid-burst abandons burst; core must be reset together.
- Counter arithmetic unsigned, no wrap: decrement never issued at 0.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN` defined: port 0 always wins ties in IDLE; `last_grant` unused. Undefined: round-robin as above.

## Test plan
- Single read: m0 rd, len=3, core accepts cycle 0 -> m0_accept=1 cycle 0, 4 acks routed to m0 with data, then IDLE; m1 sees no ack.
- Tie: m0 and m1 both rd len=0 from reset -> m0 granted first, m1 next (round-robin); with macro, m0 repeatedly granted while requesting.
- Write burst: m1 wr=4'hF len=1 -> two accepts, two acks to m1; m0 request during burst held with accept=0 until m1's second ack.
- Accept+final ack same cycle (len=0 read, zero-latency core) -> m0 accept and ack both 1 in cycle 0, state stays IDLE.
- Error: core ack with error=1 on beat 2 of m1 read len=2 -> m1_error=1 only that beat, burst completes normally.
- Reset mid-burst (after 1 of 4 acks) -> all outputs 0 during reset; afterward m0 and m1 tie grants m0.
